// File: rtl/crank_cam_gen.sv
// ---------------------------------------------------------------------------
// crank_cam_gen
// Missing-tooth crank trigger-wheel generator with a 720-degree phased cam
// output. It is the transmit end of the hwag capture path. It is used for
// on-chip loopback self-test and as a bench stimulus source.
//
// Each physical tooth occupies one "slot" of P_eff clk cycles. The last
// physical tooth (NT-1) absorbs the missing teeth, so its slot is
// (TEETH_MISSING+1)*P_eff long. Every slot is low first and then high for
// floor(P_eff/2) cycles. The gap therefore shows up as a long low phase.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   en         run request; a running slot always completes
//   period_in  clk cycles per tooth position, sampled on a slot's first cycle
//   cam_on     tooth index at which cam rises
//   cam_off    tooth index at which cam falls
//   vr_out     crank waveform
//   cam_out    cam waveform
//   tooth_num  current physical tooth, 0..NT-1
//   rev_phase  revolution parity (720-degree phase)
//   tooth_stb  one-cycle pulse on the first cycle of every slot
//   sync_stb   one-cycle pulse on the first cycle of tooth 0
//   busy       high while a slot is in progress
// ---------------------------------------------------------------------------
module crank_cam_gen #(
   parameter int TEETH_TOTAL   = 60,
   parameter int TEETH_MISSING = 2,
   parameter int DIV_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] period_in,
   input  logic [7:0]       cam_on,
   input  logic [7:0]       cam_off,
   output logic             vr_out,
   output logic             cam_out,
   output logic [7:0]       tooth_num,
   output logic             rev_phase,
   output logic             tooth_stb,
   output logic             sync_stb,
   output logic             busy
);

   localparam int               NT         = TEETH_TOTAL - TEETH_MISSING;
   localparam int               CW         = DIV_W + 4;
   localparam logic [7:0]       LAST_TOOTH = 8'(NT - 1);
   localparam logic [CW-1:0]    GAP_MULT   = CW'(TEETH_MISSING + 1);
   localparam logic [DIV_W-1:0] P_MIN      = DIV_W'(4);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [DIV_W-1:0] p_eff;
   logic             fresh;

   logic [DIV_W-1:0] p_in_clamped;
   logic [DIV_W-1:0] p_cur;
   logic [CW-1:0]    slot_len;
   logic [CW-1:0]    high_len;
   logic [CW-1:0]    cnt_inc;
   logic             last_tooth;
   logic             slot_end;
   logic [7:0]       next_tooth;
   logic             next_phase;

   // Cam level for a tooth T in revolution parity ph. When cam_on > cam_off,
   // the window wraps from the odd revolution into the even one.
   function automatic logic cam_eval(input logic [7:0] t, input logic ph,
                                     input logic [7:0] on_idx,
                                     input logic [7:0] off_idx);
      if (on_idx < off_idx)
         return ph & (t >= on_idx) & (t < off_idx);
      else if (on_idx > off_idx)
         return (ph & (t >= on_idx)) | (~ph & (t < off_idx));
      else
         return 1'b0;
   endfunction

   // Slot geometry for the slot in progress. On the first cycle of a slot
   // (cnt == 0), the period comes straight from the clamped input, because
   // p_eff is only latched at the end of that cycle. After that cycle the
   // latched copy is used, so mid-slot period changes have no effect.
   always_comb begin
      p_in_clamped = (period_in < P_MIN) ? P_MIN : period_in;
      p_cur        = (cnt == '0) ? p_in_clamped : p_eff;
      last_tooth   = (tooth_num == LAST_TOOTH);
      high_len     = CW'(p_cur >> 1);
      slot_len     = last_tooth ? (GAP_MULT * CW'(p_cur)) : CW'(p_cur);
      cnt_inc      = cnt + CW'(1);
      slot_end     = (cnt_inc == slot_len);
      next_tooth   = last_tooth ? 8'd0 : (tooth_num + 8'd1);
      next_phase   = rev_phase ^ last_tooth;
   end

   // Main sequencer. All outputs are registered, so a slot's strobes and cam
   // update appear on its first cycle. The 'fresh' flag gives a sync_stb on
   // the very first slot after reset. A resume at tooth 0 after a stop does
   // not give one, because the wrap already happened while the FSM stopped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         p_eff     <= P_MIN;
         fresh     <= 1'b1;
         vr_out    <= 1'b0;
         cam_out   <= 1'b0;
         tooth_num <= 8'd0;
         rev_phase <= 1'b0;
         tooth_stb <= 1'b0;
         sync_stb  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tooth_stb <= 1'b0;
         sync_stb  <= 1'b0;
         case (state)
            IDLE: begin
               vr_out <= 1'b0;
               busy   <= 1'b0;
               cnt    <= '0;
               if (en) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  tooth_stb <= 1'b1;
                  sync_stb  <= fresh;
                  fresh     <= 1'b0;
                  cam_out   <= cam_eval(tooth_num, rev_phase, cam_on, cam_off);
               end
            end
            RUN: begin
               if (cnt == '0)
                  p_eff <= p_in_clamped;
               if (slot_end) begin
                  cnt       <= '0;
                  vr_out    <= 1'b0;
                  tooth_num <= next_tooth;
                  rev_phase <= next_phase;
                  if (en) begin
                     tooth_stb <= 1'b1;
                     sync_stb  <= last_tooth;
                     cam_out   <= cam_eval(next_tooth, next_phase, cam_on, cam_off);
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt    <= cnt_inc;
                  vr_out <= (cnt_inc >= (slot_len - high_len));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crank_cam_gen.sv
// ---------------------------------------------------------------------------
// tb_crank_cam_gen
// Scoreboard bench for crank_cam_gen (defaults 60-2, DIV_W=16).
// The stimulus process pushes the expected tooth sequence and slot shapes
// into queues before it releases the wheel. The monitor pops one tooth
// record per tooth_stb. It also pops one slot shape (low/high cycle counts)
// whenever a slot closes.
// ---------------------------------------------------------------------------
module tb_crank_cam_gen;

   localparam int NT   = 58;
   localparam int MISS = 2;

   typedef struct {
      int tooth;
      bit sync;
      bit phase;
      bit cam;
   } toothExp_t;

   typedef struct {
      int low;
      int high;
   } slotExp_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] period_in;
   logic [7:0]  cam_on;
   logic [7:0]  cam_off;
   logic        vr_out;
   logic        cam_out;
   logic [7:0]  tooth_num;
   logic        rev_phase;
   logic        tooth_stb;
   logic        sync_stb;
   logic        busy;

   toothExp_t tq[$];
   slotExp_t  sq[$];

   int total = 0;
   int bad   = 0;
   int stbCount = 0;
   int expT;
   bit expPh;
   int camOnE;
   int camOffE;
   int idleBad;

   bit        measuring = 0;
   int        lowCnt;
   int        highCnt;
   bit        shapeErr;
   toothExp_t monTe;
   slotExp_t  monSe;

   crank_cam_gen dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .period_in (period_in),
      .cam_on    (cam_on),
      .cam_off   (cam_off),
      .vr_out    (vr_out),
      .cam_out   (cam_out),
      .tooth_num (tooth_num),
      .rev_phase (rev_phase),
      .tooth_stb (tooth_stb),
      .sync_stb  (sync_stb),
      .busy      (busy)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A hard time limit, so that a stuck design cannot hang the run.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int unsigned act,
                              input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic bit camModel(input int t, input bit ph);
      if (camOnE < camOffE)
         return ph && (t >= camOnE) && (t < camOffE);
      else if (camOnE > camOffE)
         return (ph && (t >= camOnE)) || (!ph && (t < camOffE));
      else
         return 1'b0;
   endfunction

   // Queue one tooth: its strobe record and, optionally, its slot shape.
   // Then advance the expected wheel position.
   task automatic pushTooth(input int p, input bit sync, input bit shape);
      toothExp_t te;
      slotExp_t  se;
      int pe, s, h;
      te.tooth = expT;
      te.sync  = sync;
      te.phase = expPh;
      te.cam   = camModel(expT, expPh);
      tq.push_back(te);
      pe = (p < 4) ? 4 : p;
      h  = pe / 2;
      s  = (expT == NT - 1) ? (MISS + 1) * pe : pe;
      se.low  = s - h;
      se.high = h;
      if (shape)
         sq.push_back(se);
      if (expT == NT - 1) begin
         expT  = 0;
         expPh = ~expPh;
      end else begin
         expT++;
      end
   endtask

   task automatic pushRun(input int count, input int p, input bit firstSync);
      for (int i = 0; i < count; i++)
         pushTooth(p, (i == 0) ? firstSync : (expT == 0), 1'b1);
   endtask

   task automatic applyStimulus(input logic e, input int p, input int con,
                                input int coff);
      @(posedge clk);
      #1;
      en        = e;
      period_in = 16'(p);
      cam_on    = 8'(con);
      cam_off   = 8'(coff);
   endtask

   task automatic waitStb(input int target, input int budget);
      int n;
      n = 0;
      while (stbCount < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (stbCount < target)
         checkOutput("wait_tooth_stb_timeout", stbCount, target);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("wait_idle_busy", busy, 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_vr_out"}, vr_out, 0);
      checkOutput({tag, "_cam_out"}, cam_out, 0);
      checkOutput({tag, "_tooth_num"}, tooth_num, 0);
      checkOutput({tag, "_rev_phase"}, rev_phase, 0);
      checkOutput({tag, "_tooth_stb"}, tooth_stb, 0);
      checkOutput({tag, "_sync_stb"}, sync_stb, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   task automatic closeSlot();
      measuring = 0;
      checkOutput("vr_low_then_high_order", shapeErr, 0);
      if (sq.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL unexpected_slot: got low=%0d high=%0d want none", lowCnt, highCnt);
      end else begin
         monSe = sq.pop_front();
         checkOutput("slot_low_cycles", lowCnt, monSe.low);
         checkOutput("slot_high_cycles", highCnt, monSe.high);
      end
   endtask

   // The monitor samples on the falling edge. It closes a slot when the next
   // slot starts or when busy drops. It checks every tooth_stb against the
   // queue head and counts the vr_out low and high cycles of each slot. A
   // reset discards the slot that was in progress.
   always @(negedge clk) begin
      if (!rst) begin
         measuring = 0;
      end else begin
         if (measuring && (tooth_stb || !busy))
            closeSlot();
         if (!busy)
            checkOutput("idle_stb_vr", {29'd0, tooth_stb, sync_stb, vr_out}, 0);
         if (sync_stb)
            checkOutput("sync_with_tooth_stb", tooth_stb, 1);
         if (tooth_stb) begin
            stbCount++;
            if (tq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_tooth_stb: got tooth %0d want no strobe", tooth_num);
            end else begin
               monTe = tq.pop_front();
               checkOutput("tooth_num", tooth_num, monTe.tooth);
               checkOutput("sync_stb", sync_stb, monTe.sync);
               checkOutput("rev_phase", rev_phase, monTe.phase);
               checkOutput("cam_out", cam_out, monTe.cam);
            end
            measuring = 1;
            lowCnt    = 0;
            highCnt   = 0;
            shapeErr  = 0;
         end
         if (measuring) begin
            if (vr_out) begin
               highCnt++;
            end else begin
               if (highCnt != 0)
                  shapeErr = 1;
               lowCnt++;
            end
         end
      end
   end

   // The directed sequence: reset and idle, then a basic wheel with period
   // changes, a stop and resume mid-revolution, a stop at the gap tooth, the
   // wrapping cam window and the null cam window, and a mid-slot reset.
   initial begin
      rst       = 1'b0;
      en        = 1'b0;
      period_in = 16'd8;
      cam_on    = 8'd4;
      cam_off   = 8'd54;
      camOnE    = 4;
      camOffE   = 54;
      expT      = 0;
      expPh     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b1;
      idleBad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (vr_out || cam_out || tooth_num != 0 || rev_phase || tooth_stb || sync_stb || busy)
            idleBad++;
      end
      checkOutput("idle_100_cycles_nonzero", idleBad, 0);

      // Two full revolutions at P=8, then into the third one.
      pushRun(126, 8, 1'b1);
      applyStimulus(1'b1, 8, 4, 54);
      waitStb(126, 2000);
      period_in = 16'd12;
      pushRun(11, 12, 1'b0);
      waitStb(137, 500);
      period_in = 16'd9;
      pushRun(10, 9, 1'b0);
      waitStb(147, 500);
      en = 1'b0;
      waitIdle(100);
      checkOutput("stop30_tooth_num", tooth_num, 31);
      checkOutput("stop30_rev_phase", rev_phase, 0);
      checkOutput("stop30_vr_out", vr_out, 0);

      // Resume at tooth 31 with period_in=1 (clamped to 4).
      repeat (5) @(posedge clk);
      pushRun(27, 1, 1'b0);
      applyStimulus(1'b1, 1, 4, 54);
      @(posedge clk);
      #1;
      checkOutput("resume31_tooth_stb", tooth_stb, 1);
      checkOutput("resume31_tooth_num", tooth_num, 31);
      checkOutput("resume31_sync_stb", sync_stb, 0);
      waitStb(174, 400);
      en = 1'b0;
      waitIdle(50);
      checkOutput("stop57_tooth_num", tooth_num, 0);
      checkOutput("stop57_rev_phase", rev_phase, 1);
      checkOutput("stop57_vr_out", vr_out, 0);

      // Cam window wrapping across revolutions, resumed at tooth 0.
      repeat (4) @(posedge clk);
      camOnE  = 50;
      camOffE = 10;
      pushRun(122, 8, 1'b0);
      applyStimulus(1'b1, 8, 50, 10);
      @(posedge clk);
      #1;
      checkOutput("resume0_tooth_stb", tooth_stb, 1);
      checkOutput("resume0_sync_stb", sync_stb, 0);
      waitStb(296, 2000);
      en = 1'b0;
      waitIdle(50);
      checkOutput("stop5_tooth_num", tooth_num, 6);
      checkOutput("stop5_rev_phase", rev_phase, 1);

      // Null cam window, then a reset in the middle of tooth 3.
      camOnE  = 20;
      camOffE = 20;
      pushRun(55, 8, 1'b0);
      pushTooth(8, 1'b0, 1'b0);
      applyStimulus(1'b1, 8, 20, 20);
      waitStb(352, 1000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b0;
      @(posedge clk);
      #1;
      checkAllZero("midslot_reset");
      rst = 1'b1;

      // First tooth 0 after reset gets sync_stb with rev_phase still 0.
      expT  = 0;
      expPh = 1'b0;
      pushRun(6, 8, 1'b1);
      applyStimulus(1'b1, 8, 20, 20);
      waitStb(358, 200);
      en = 1'b0;
      waitIdle(50);
      checkOutput("post_reset_tooth_num", tooth_num, 6);
      checkOutput("post_reset_rev_phase", rev_phase, 0);

      repeat (3) @(posedge clk);
      checkOutput("tooth_queue_left", tq.size(), 0);
      checkOutput("slot_queue_left", sq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crank_cam_gen.md
Name: crank_cam_gen

Overview:
- Synthesizable crank/cam trigger-wheel generator; the transmit end of the hwag capture input.
- Produces a missing-tooth crank waveform (default 60-2) and a 720°-phased cam signal from a programmable tooth period.
- Used for on-chip self-test loopback into hwag cap_in and as a bench stimulus source.

Parameters:
TEETH_TOTAL, 60, tooth positions per revolution including the missing ones
TEETH_MISSING, 2, missing teeth (1..15)
DIV_W, 16, width of the tooth period in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
en  in  1  run request
period_in  in  DIV_W  clk cycles per tooth position (P)
cam_on  in  8  tooth index at which cam rises
cam_off  in  8  tooth index at which cam falls
vr_out  out  1  crank waveform
cam_out  out  1  cam waveform
tooth_num  out  8  current physical tooth index, 0..NT-1, where NT = TEETH_TOTAL-TEETH_MISSING
rev_phase  out  1  revolution parity (720° phase)
tooth_stb  out  1  1-cycle pulse on the first cycle of each tooth slot
sync_stb  out  1  1-cycle pulse on the first cycle of tooth 0
busy  out  1  high while a slot is in progress

Behaviour:
- Reset (rst=0 at a clk edge) clears everything in that cycle: vr_out=0, cam_out=0, tooth_num=0, rev_phase=0, tooth_stb=0, sync_stb=0, busy=0, FSM=IDLE, slot counter=0. Reset mid-slot aborts the slot immediately.
- FSM states:
  - IDLE: vr_out=0 and busy=0; cam_out holds its value.
  - RUN: a slot is in progress.
- IDLE->RUN: en=1 sampled at edge t. The slot starts at t+1 with busy=1 and tooth_stb=1; the slot counter is 0 on that cycle.
- Period latch:
  - P_eff is latched from period_in only on a slot's first cycle.
  - period_in < 4 clamps to 4.
  - Changes to period_in mid-slot are ignored.
- Slot length S:
  - Normal teeth: S = P_eff.
  - Tooth NT-1: S = (TEETH_MISSING+1)*P_eff.
  - The internal slot counter is DIV_W+4 bits wide; no overflow is possible.
- Waveform within a slot:
  - H = floor(P_eff/2).
  - vr_out = 0 for the first S-H cycles and 1 for the last H cycles.
  - The gap is therefore an extended low; the high width is the same for every tooth.
- Slot end (counter = S-1) with en=1:
  - The next slot starts on the following cycle with no idle cycle.
  - tooth_num increments; NT-1 wraps to 0.
  - On that wrap, rev_phase toggles and sync_stb=1 together with tooth_stb.
  - After reset, the first tooth 0 slot pulses tooth_stb and sync_stb, but rev_phase stays 0.
- en=0 during RUN:
  - The current slot completes.
  - At slot end the FSM enters IDLE, vr_out=0, busy=0.
  - tooth_num advances to the next tooth, and rev_phase is updated if that tooth is 0.
  - A later en=1 resumes from that tooth; no strobe is issued until it resumes.
- Cam (updated at each slot start, registered; cam_out changes in the same cycle as tooth_stb), with T = the new tooth_num and ph = the new rev_phase:
  - cam_on < cam_off: cam_out = ph & (T >= cam_on) & (T < cam_off).
  - cam_on > cam_off (wraps across revolutions): cam_out = (ph & T >= cam_on) | (~ph & T < cam_off).
  - cam_on == cam_off: cam_out = 0.
  - Values >= NT behave as compared; a value never reached means no edge on that side.
- tooth_stb and sync_stb are exactly one cycle wide and never asserted in IDLE.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, en=0 -> all outputs 0 and stay 0 for 100 cycles; rst=0 asserted mid-slot in RUN -> all outputs 0 on the next edge.
- Basic wheel, P=8, en held at 1:
  - Teeth 0..56: each slot is 4 low + 4 high.
  - Tooth 57: 20 low + 4 high.
  - Revolution = 57*8+24 = 480 cycles; sync_stb every 480 cycles.
  - tooth_stb count per revolution = 58.
  - rev_phase toggles at each sync_stb after the first.
- Period handling:
  - period_in changed from 8 to 12 mid-slot -> the current slot stays 8 and the next is 12 (6 low, 6 high).
  - period_in=1 -> slot of 4, 2 low, 2 high.
  - Odd P=9 -> 5 low, 4 high.
- Cam, cam_on=4 and cam_off=54:
  - cam_out rises with tooth_stb of tooth 4 and falls with tooth_stb of tooth 54, only while rev_phase=1.
  - cam_out stays 0 throughout rev_phase=0.
- Cam wrap, cam_on=50 and cam_off=10 -> cam_out high from tooth 50 of phase 1 through tooth 9 of phase 0, falling at tooth 10; cam_on=cam_off=20 -> cam_out never 1.
- Stop/resume:
  - en dropped during tooth 30 -> tooth 30 completes, then busy=0 and vr_out=0, tooth_num=31.
  - en re-raised -> tooth_stb on the next cycle with tooth_num=31 and no sync_stb.
  - en dropped during tooth 57 -> stops with tooth_num=0 and toggled rev_phase; resume gives no sync_stb until the next wrap.
